// File: rtl/mic_frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : mic_frame_writer
// Description : Packs NUM_CH-sample microphone frames into the second port of
//               a dual-port RAM using ping-pong banks. Raises irq while a full
//               bank awaits software, and counts frames dropped while the
//               current bank is still owned by software.
//               Optional feature macro: MIC_FRAME_HEADER_EN (bank header word).
// Revision    : 1.0 - initial release
// ============================================================================
module mic_frame_writer #(
    parameter int NUM_CH   = 4,
    parameter int SAMPLE_W = 24,
    parameter int ADDR_W   = 9
) (
    input  logic                         clk_clk,
    input  logic                         reset_reset_n,
    input  logic                         sample_valid,
    output logic                         sample_ready,
    input  logic [NUM_CH*SAMPLE_W-1:0]   sample_data,
    output logic [ADDR_W-1:0]            ram_address,
    output logic                         ram_chipselect,
    output logic                         ram_clken,
    output logic                         ram_write,
    output logic [31:0]                  ram_writedata,
    output logic [3:0]                   ram_byteenable,
    output logic                         irq,
    output logic [1:0]                   bank_pending,
    input  logic [1:0]                   irq_ack,
    output logic [15:0]                  overrun_count
);

    localparam int c_off_w = ADDR_W - 1;
`ifdef MIC_FRAME_HEADER_EN
    localparam int c_hdr_words = 1;
`else
    localparam int c_hdr_words = 0;
`endif
    localparam int c_frames_per_bank = ((1 << c_off_w) - c_hdr_words) / NUM_CH;
    localparam int c_frm_w = ADDR_W;

    localparam logic [c_off_w-1:0] c_off_one    = c_off_w'(1);
    localparam logic [c_frm_w-1:0] c_frm_one    = c_frm_w'(1);
    localparam logic [c_frm_w-1:0] c_last_frame = c_frm_w'(c_frames_per_bank - 1);
    localparam logic [4:0]         c_last_ch    = 5'(NUM_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_WR   = 2'd2
    } state_t;

    state_t                      r_state;
    logic                        r_ready;
    logic                        r_bank;
    logic [c_off_w-1:0]          r_offset;
    logic [c_frm_w-1:0]          r_frames;
    logic [4:0]                  r_ch;
    logic [15:0]                 r_seq;
    logic [1:0]                  r_pending;
    logic [15:0]                 r_overrun;
    logic [NUM_CH*SAMPLE_W-1:0]  r_shadow;
    logic                        r_cs;
    logic [ADDR_W-1:0]           r_address;
    logic [31:0]                 r_wdata;

    logic                        w_accept;
    logic                        w_drop;
    logic                        w_bank_done;
    logic [1:0]                  w_pend_set;
    logic [4:0]                  w_next_ch;
    logic [SAMPLE_W-1:0]         w_next_sample;
    logic [31:0]                 w_next_word;
    logic [31:0]                 w_first_in_word;
`ifdef MIC_FRAME_HEADER_EN
    logic [31:0]                 w_shadow0_word;
`endif

    // r_ready is only ever high in S_IDLE, so it alone qualifies an accept
    assign w_accept    = sample_valid & r_ready;
    assign w_drop      = r_pending[r_bank];
    assign w_next_ch   = r_ch + 5'd1;
    assign w_bank_done = (r_state == S_WR) && (r_ch == c_last_ch) && (r_frames == c_last_frame);
    assign w_pend_set  = w_bank_done ? (r_bank ? 2'b10 : 2'b01) : 2'b00;

    assign w_first_in_word = 32'($signed(sample_data[SAMPLE_W-1:0]));
    assign w_next_word     = 32'($signed(w_next_sample));
`ifdef MIC_FRAME_HEADER_EN
    assign w_shadow0_word  = 32'($signed(r_shadow[SAMPLE_W-1:0]));
`endif

    // Select the shadowed sample for the channel written on the next cycle
    always_comb begin
        w_next_sample = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_next_ch == 5'(i)) begin
                w_next_sample = r_shadow[i*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    // Frame FSM: accept/drop, header and sample writes, banking, pending flags
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b0;
            r_bank    <= 1'b0;
            r_offset  <= '0;
            r_frames  <= '0;
            r_ch      <= '0;
            r_seq     <= '0;
            r_pending <= '0;
            r_overrun <= '0;
            r_shadow  <= '0;
            r_cs      <= 1'b0;
            r_address <= '0;
            r_wdata   <= '0;
        end else begin
            // A completion set takes priority over a same-cycle acknowledge
            r_pending <= (r_pending & ~irq_ack) | w_pend_set;

            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_seq <= r_seq + 16'd1;
                        if (w_drop) begin
                            if (r_overrun != 16'hFFFF) begin
                                r_overrun <= r_overrun + 16'd1;
                            end
                        end else begin
                            r_shadow  <= sample_data;
                            r_ready   <= 1'b0;
                            r_cs      <= 1'b1;
                            r_address <= {r_bank, r_offset};
                            r_offset  <= r_offset + c_off_one;
`ifdef MIC_FRAME_HEADER_EN
                            if (r_offset == '0) begin
                                // Header carries the sequence number of this frame
                                r_state <= S_HDR;
                                r_wdata <= {8'hA5, 8'(NUM_CH), r_seq};
                            end else begin
                                r_state <= S_WR;
                                r_ch    <= '0;
                                r_wdata <= w_first_in_word;
                            end
`else
                            r_state <= S_WR;
                            r_ch    <= '0;
                            r_wdata <= w_first_in_word;
`endif
                        end
                    end
                end
`ifdef MIC_FRAME_HEADER_EN
                S_HDR: begin
                    r_state   <= S_WR;
                    r_ch      <= '0;
                    r_address <= {r_bank, r_offset};
                    r_offset  <= r_offset + c_off_one;
                    r_wdata   <= w_shadow0_word;
                end
`endif
                S_WR: begin
                    if (r_ch == c_last_ch) begin
                        r_state <= S_IDLE;
                        r_cs    <= 1'b0;
                        r_ready <= 1'b1;
                        if (r_frames == c_last_frame) begin
                            // Bank full: hand it to software and flip banks
                            r_frames <= '0;
                            r_bank   <= ~r_bank;
                            r_offset <= '0;
                        end else begin
                            r_frames <= r_frames + c_frm_one;
                        end
                    end else begin
                        r_ch      <= w_next_ch;
                        r_address <= {r_bank, r_offset};
                        r_offset  <= r_offset + c_off_one;
                        r_wdata   <= w_next_word;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cs    <= 1'b0;
                end
            endcase
        end
    end

    assign sample_ready   = r_ready;
    assign ram_address    = r_address;
    assign ram_chipselect = r_cs;
    assign ram_clken      = r_cs;
    assign ram_write      = r_cs;
    assign ram_writedata  = r_wdata;
    assign ram_byteenable = {4{r_cs}};
    assign bank_pending   = r_pending;
    assign irq            = |r_pending;
    assign overrun_count  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_mic_frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mic_frame_writer
// Description : Self-checking bench for mic_frame_writer (NUM_CH=4,
//               SAMPLE_W=24, ADDR_W=5). A frame-level reference model turns
//               each accepted frame into a queue of expected RAM writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mic_frame_writer;

    localparam int NUM_CH   = 4;
    localparam int SAMPLE_W = 24;
    localparam int ADDR_W   = 5;
`ifdef MIC_FRAME_HEADER_EN
    localparam int H  = 1;
    localparam int NT = 4;
`else
    localparam int H  = 0;
    localparam int NT = 5;
`endif
    localparam int HALF = 16;
    localparam int FPB  = (HALF - H) / NUM_CH;
    localparam logic [95:0] PAT = {24'h800003, 24'h800002, 24'h800001, 24'h800000};

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        valid = 1'b0;
    logic [95:0] data  = '0;
    logic [1:0]  ack   = '0;

    logic        sample_ready;
    logic [4:0]  ram_address;
    logic        ram_chipselect;
    logic        ram_clken;
    logic        ram_write;
    logic [31:0] ram_writedata;
    logic [3:0]  ram_byteenable;
    logic        irq;
    logic [1:0]  bank_pending;
    logic [15:0] overrun_count;

    mic_frame_writer #(
        .NUM_CH   (NUM_CH),
        .SAMPLE_W (SAMPLE_W),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk_clk        (clk),
        .reset_reset_n  (rst_n),
        .sample_valid   (valid),
        .sample_ready   (sample_ready),
        .sample_data    (data),
        .ram_address    (ram_address),
        .ram_chipselect (ram_chipselect),
        .ram_clken      (ram_clken),
        .ram_write      (ram_write),
        .ram_writedata  (ram_writedata),
        .ram_byteenable (ram_byteenable),
        .irq            (irq),
        .bank_pending   (bank_pending),
        .irq_ack        (irq_ack_w),
        .overrun_count  (overrun_count)
    );

    logic [1:0] irq_ack_w;
    assign irq_ack_w = ack;

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic        last;
    } wr_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [1:0]  pend;
    } vec_t;

    wr_t         wq[$];
    logic [1:0]  m_pend;
    logic        m_bank;
    int          m_off;
    int          m_frames;
    logic [15:0] m_seq;
    logic [15:0] m_over;
    logic        m_live;

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sx(input logic [23:0] s);
        return {{8{s[23]}}, s};
    endfunction

    task automatic model_reset();
        wq.delete();
        m_pend   = '0;
        m_bank   = 1'b0;
        m_off    = 0;
        m_frames = 0;
        m_seq    = '0;
        m_over   = '0;
        m_live   = 1'b0;
    endtask

    task automatic enqueue(input logic [95:0] d);
        wr_t e;
        if (H == 1 && m_off == 0) begin
            e.a    = {m_bank, 4'(m_off)};
            e.d    = {8'hA5, 8'(NUM_CH), m_seq};
            e.last = 1'b0;
            wq.push_back(e);
            m_off++;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            e.a    = {m_bank, 4'(m_off)};
            e.d    = sx(d[k*SAMPLE_W +: SAMPLE_W]);
            e.last = (k == NUM_CH - 1) && (m_frames == FPB - 1);
            wq.push_back(e);
            m_off++;
        end
        m_frames++;
        if (m_frames == FPB) begin
            m_bank   = ~m_bank;
            m_off    = 0;
            m_frames = 0;
        end
    endtask

    // One clock: check outputs at the falling edge, drive inputs, advance model
    task automatic cycle(input logic v, input logic [95:0] d, input logic [1:0] ak);
        wr_t        e;
        logic [1:0] set;
        logic       exp_rdy;
        set     = 2'b00;
        exp_rdy = m_live && (wq.size() == 0);
        chk("sample_ready", 32'(sample_ready), 32'(exp_rdy));
        if (wq.size() > 0) begin
            e = wq.pop_front();
            chk("ram_chipselect", 32'(ram_chipselect), 32'd1);
            chk("ram_clken", 32'(ram_clken), 32'd1);
            chk("ram_write", 32'(ram_write), 32'd1);
            chk("ram_address", 32'(ram_address), 32'(e.a));
            chk("ram_writedata", ram_writedata, e.d);
            chk("ram_byteenable", 32'(ram_byteenable), 32'hF);
            if (e.last) set = e.a[4] ? 2'b10 : 2'b01;
        end else begin
            chk("idle_chipselect", 32'(ram_chipselect), 32'd0);
            chk("idle_clken_write", 32'({ram_clken, ram_write}), 32'd0);
            chk("idle_byteenable", 32'(ram_byteenable), 32'd0);
        end
        chk("bank_pending", 32'(bank_pending), 32'(m_pend));
        chk("irq", 32'(irq), 32'(|m_pend));
        chk("overrun_count", 32'(overrun_count), 32'(m_over));

        valid = v;
        data  = d;
        ack   = ak;
        if (v && exp_rdy) begin
            if (m_pend[m_bank]) begin
                if (m_over != 16'hFFFF) m_over = m_over + 16'd1;
            end else begin
                enqueue(d);
            end
            m_seq = m_seq + 16'd1;
        end
        m_pend = (m_pend & ~ak) | set;
        m_live = rst_n;
        @(negedge clk);
        valid = 1'b0;
        ack   = 2'b00;
    endtask

    task automatic wait_ready();
        int g = 0;
        while (!(m_live && wq.size() == 0) && g < 50) begin
            cycle(1'b0, '0, 2'b00);
            g++;
        end
        chk("ready_wait_bound", 32'(g < 50), 32'd1);
    endtask

    task automatic drain();
        int g = 0;
        while (wq.size() > 0 && g < 50) begin
            cycle(1'b0, '0, 2'b00);
            g++;
        end
        chk("drain_bound", 32'(g < 50), 32'd1);
    endtask

    task automatic send_frame(input logic [95:0] d, output logic [4:0] fa,
                              output logic [31:0] fd, output logic fcs,
                              output logic [1:0] pa);
        wait_ready();
        cycle(1'b1, d, 2'b00);
        fa  = ram_address;
        fd  = ram_writedata;
        fcs = ram_chipselect;
        drain();
        pa  = bank_pending;
    endtask

    task automatic send_frame_ack_last(input logic [95:0] d, input logic [1:0] ak);
        int g = 0;
        wait_ready();
        cycle(1'b1, d, 2'b00);
        while (wq.size() > 1 && g < 50) begin
            cycle(1'b0, '0, 2'b00);
            g++;
        end
        chk("ack_last_bound", 32'(g < 50), 32'd1);
        cycle(1'b0, '0, ak);
    endtask

    // Asynchronous reset applied between clock edges
    task automatic do_reset_async();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ready", 32'(sample_ready), 32'd0);
        chk("rst_cs_clken_write", 32'({ram_chipselect, ram_clken, ram_write}), 32'd0);
        chk("rst_address", 32'(ram_address), 32'd0);
        chk("rst_writedata", ram_writedata, 32'd0);
        chk("rst_byteenable", 32'(ram_byteenable), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_pending", 32'(bank_pending), 32'd0);
        chk("rst_overrun", 32'(overrun_count), 32'd0);
        model_reset();
        @(negedge clk);
        cycle(1'b0, '0, 2'b00);
        cycle(1'b0, '0, 2'b00);
        rst_n = 1'b1;
        cycle(1'b0, '0, 2'b00);
        cycle(1'b0, '0, 2'b00);
    endtask

    initial begin
        vec_t        tbl[NT];
        logic [4:0]  fa;
        logic [31:0] fd;
        logic        fcs;
        logic [1:0]  pa;
        logic        rh[15];
        int          g;

`ifdef MIC_FRAME_HEADER_EN
        tbl[0] = '{addr: 5'd0,  data: 32'hA5040000, pend: 2'b00};
        tbl[1] = '{addr: 5'd5,  data: 32'hFF800000, pend: 2'b00};
        tbl[2] = '{addr: 5'd9,  data: 32'hFF800000, pend: 2'b01};
        tbl[3] = '{addr: 5'd16, data: 32'hA5040003, pend: 2'b01};
`else
        tbl[0] = '{addr: 5'd0,  data: 32'hFF800000, pend: 2'b00};
        tbl[1] = '{addr: 5'd4,  data: 32'hFF800000, pend: 2'b00};
        tbl[2] = '{addr: 5'd8,  data: 32'hFF800000, pend: 2'b00};
        tbl[3] = '{addr: 5'd12, data: 32'hFF800000, pend: 2'b01};
        tbl[4] = '{addr: 5'd16, data: 32'hFF800000, pend: 2'b01};
`endif

        model_reset();
        do_reset_async();

        // Directed frames through bank 0 into bank 1
        for (int i = 0; i < NT; i++) begin
            send_frame(PAT, fa, fd, fcs, pa);
            chk("tbl_first_addr", 32'(fa), 32'(tbl[i].addr));
            chk("tbl_first_data", fd, tbl[i].data);
            chk("tbl_pend_after", 32'(pa), 32'(tbl[i].pend));
        end

        // Fill both banks, then drop four frames
        g = 0;
        while (m_pend != 2'b11 && g < 20) begin
            send_frame(PAT, fa, fd, fcs, pa);
            g++;
        end
        chk("both_banks_pending", 32'(bank_pending), 32'h3);
        for (int i = 0; i < 4; i++) begin
            send_frame(PAT ^ 96'(i), fa, fd, fcs, pa);
            chk("drop_no_write", 32'(fcs), 32'd0);
        end
        chk("overrun_after_drops", 32'(overrun_count), 32'd4);
        cycle(1'b0, '0, 2'b01);
        send_frame(PAT, fa, fd, fcs, pa);
        chk("after_drop_cs", 32'(fcs), 32'd1);
        chk("after_drop_addr", 32'(fa), 32'd0);

        // Acknowledge colliding with the set of the same bank
        cycle(1'b0, '0, 2'b10);
        g = 0;
        while (m_frames != FPB - 1 && g < 20) begin
            send_frame(PAT, fa, fd, fcs, pa);
            g++;
        end
        send_frame_ack_last(PAT, 2'b01);
        chk("set_wins_over_ack", 32'(bank_pending), 32'h1);
        cycle(1'b0, '0, 2'b10);
        chk("ack_nonpending_ignored", 32'(bank_pending), 32'h1);
        cycle(1'b0, '0, 2'b01);
        chk("irq_falls_after_ack", 32'(irq), 32'd0);

        // Back-to-back frames with sample_valid held high
        send_frame(PAT, fa, fd, fcs, pa);
        for (int i = 0; i < 15; i++) begin
            rh[i] = sample_ready;
            cycle(1'b1, {$urandom, $urandom, $urandom}, 2'b00);
        end
        for (int i = 0; i < 10; i++) begin
            chk("b2b_ready_pattern", 32'(rh[i]), 32'(i % 5 == 0));
        end
        drain();

        // Randomized traffic with sporadic acknowledges
        for (int i = 0; i < 400; i++) begin
            logic       v;
            logic [1:0] ak;
            v  = ($urandom_range(0, 3) != 0);
            ak = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cycle(v, {$urandom, $urandom, $urandom}, ak);
        end
        drain();

        // Reset in the middle of a frame write
        cycle(1'b0, '0, 2'b11);
        wait_ready();
        cycle(1'b1, PAT, 2'b00);
        cycle(1'b0, '0, 2'b00);
        cycle(1'b0, '0, 2'b00);
        chk("mid_frame_writing", 32'(ram_chipselect), 32'd1);
        do_reset_async();
        send_frame(PAT, fa, fd, fcs, pa);
        chk("post_reset_cs", 32'(fcs), 32'd1);
        chk("post_reset_addr", 32'(fa), 32'd0);
        chk("post_reset_overrun", 32'(overrun_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mic_frame_writer.md
# mic_frame_writer

Multi-channel microphone sample packer that writes frames of NUM_CH samples into the dual-port RAM block's second port and raises an interrupt to the Nios II when a buffer half fills. It sits between the mic-array front end (PDM/I2S decimators) and the `ram_block_s2_*` port, driving `ext_irq_adapter_new_signal`. It generalises the former single-channel fixed-address writer with:
- configurable channel count, sample width and depth;
- ping-pong banking with per-bank acknowledge;
- overrun accounting.

## Interface
- NUM_CH, 4, channels per frame (1..16)
- SAMPLE_W, 24, bits per sample (8..32), signed
- ADDR_W, 9, RAM word-address width; bank half = 2^(ADDR_W-1) words

Ports:
- clk_clk  in  1  single clock for all logic
- reset_reset_n  in  1  asynchronous, active-low reset
- sample_valid  in  1  frame present on sample_data
- sample_ready  out  1  block accepts a frame this cycle
- sample_data  in  NUM_CH*SAMPLE_W  channel 0 in LSBs
- ram_address  out  ADDR_W  word address; MSB = bank
- ram_chipselect  out  1  write cycle active
- ram_clken  out  1  equals ram_chipselect
- ram_write  out  1  equals ram_chipselect
- ram_writedata  out  32  sign-extended sample or header
- ram_byteenable  out  4  4'hF while writing, else 4'h0
- irq  out  1  OR of bank_pending
- bank_pending  out  2  bank full, owned by software
- irq_ack  in  2  one-cycle pulse per bit clears that bank's pending flag
- overrun_count  out  16  dropped frames, saturating

## Operation
- FSM states:
  - S_IDLE: sample_ready=1.
  - S_HDR: header write; only with the macro.
  - S_WR: one word per cycle, channel index ch from 0 to NUM_CH-1.
- Accept: sample_valid & sample_ready in S_IDLE latches sample_data into a shadow register. The frame sequence counter seq (16-bit, wraps) increments on every accepted frame, including dropped frames.
- Accept action depends on the current bank b:
  - pending[b]=0: go to S_WR, or to S_HDR when offset=0 and the header is enabled.
  - pending[b]=1: drop mode. The frame is discarded, overrun_count increments (holds at 16'hFFFF), and the FSM stays in S_IDLE.
  - Drop mode ends at the first frame accepted after pending[b] clears. That frame is written at offset 0.
- Writes:
  - ram_address = {b, offset}; offset increments per word.
  - Data = sample[ch] sign-extended to 32 bits.
- FRAMES_PER_BANK = floor((2^(ADDR_W-1) - H)/NUM_CH), where H = 1 with the header and 0 without. The RAM parameters must give FRAMES_PER_BANK ≥ 1. Words beyond the last frame are never written.
- Bank completion: after the last word of frame FRAMES_PER_BANK, the block:
  - sets pending[b];
  - toggles b;
  - resets offset to 0.
- Pending flags: irq_ack[i] clears pending[i]. An ack to a non-pending bank is ignored. A set and an ack of the same bank in the same cycle: set wins.
- Reset (async, any state) forces:
  - FSM to S_IDLE; b=0, offset=0, seq=0;
  - pending=0, overrun_count=0;
  - ram_chipselect/clken/write=0, ram_address=0, ram_writedata=0, ram_byteenable=0, irq=0.
  - sample_ready=0 while reset is asserted; 1 in the first cycle after release.

## Timing
- Frame accepted at edge T: writes occur on cycles T+1 … T+NUM_CH (shifted +1 when a header precedes them).
- sample_ready is low during S_HDR/S_WR. It returns high in the cycle after the last write.
- Maximum frame rate: one per NUM_CH+1 cycles (NUM_CH+2 for a bank's first frame with header).
- pending[b] and irq rise in the cycle after the bank's last write, registered.
- irq falls in the cycle after irq_ack clears the last pending bit.
- Drop-mode accepts produce no RAM activity. overrun_count updates the cycle after the accept.

## Configuration
- MIC_FRAME_HEADER_EN defined:
  - Offset 0 of every bank holds the header {8'hA5, 8'(NUM_CH), seq of the bank's first frame}.
  - The header is written in S_HDR immediately before that frame's samples.
  - Frames start at offset 1.
- MIC_FRAME_HEADER_EN undefined:
  - S_HDR is absent; frames start at offset 0.
  - FRAMES_PER_BANK uses H=0.

## Test plan
- NUM_CH=4, ADDR_W=5, no header, 4 frames with ch k = 24'h800000+k → addresses 0..15 receive 32'hFF800000..32'hFF800003 repeating; irq=1 and bank_pending=2'b01 one cycle after address 15; next frame writes address 16.
- Same config, 12 frames without ack → bank 0 filled, bank 1 filled, then 4 frames dropped; overrun_count=4; no RAM writes while dropping; irq_ack=2'b01 then one frame → written at address 0.
- MIC_FRAME_HEADER_EN, NUM_CH=4, ADDR_W=5 → address 0 = 32'hA5040000; 3 frames at addresses 1..12; pending after address 12; bank 1 header = 32'hA5040003.
- Back-to-back sample_valid held high → sample_ready pattern 1,0,0,0,0 repeats (NUM_CH=4); exactly one write per cycle.
- irq_ack[0] in the same cycle pending[0] is set → pending[0] stays 1; ack of non-pending bank 1 → no change.
- reset_reset_n asserted mid-S_WR (ch=2) → all outputs zero asynchronously; after release, first frame writes address 0; overrun_count=0.
